// File: rtl/stream_arbiter_rr.sv
// N-input AXI-Stream packet arbiter: round-robin or fixed-priority grant, locked
// for the duration of a packet, with a registered output stage and source-ID sideband.
module stream_arbiter_rr #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 64,
   parameter int ID_W    = 2,
   parameter int MODE    = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [N_PORTS-1:0]        i_port_enable,
   input  logic [N_PORTS*DATA_W-1:0] i_s_axis_tdata,
   input  logic [N_PORTS-1:0]        i_s_axis_tvalid,
   input  logic [N_PORTS-1:0]        i_s_axis_tlast,
   output logic [N_PORTS-1:0]        o_s_axis_tready,
   output logic [DATA_W-1:0]         o_m_axis_tdata,
   output logic                      o_m_axis_tvalid,
   output logic                      o_m_axis_tlast,
   output logic [ID_W-1:0]           o_m_axis_tid,
   input  logic                      i_m_axis_tready,
   output logic                      o_busy,
   output logic [ID_W-1:0]           o_dbg_ptr
);

   localparam int CW = ID_W + 1;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t              r_state;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_grant;

   logic                accept;
   logic                hs;
   logic [N_PORTS-1:0]  cand;
   logic [N_PORTS-1:0]  rot;
   logic [ID_W-1:0]     base;
   logic [CW-1:0]       sum;
   logic                arb_found;
   logic [ID_W-1:0]     arb_idx;
   logic                grant_vld;
   logic [ID_W-1:0]     grant;
   logic [ID_W-1:0]     next_ptr;
   logic [DATA_W-1:0]   sel_data;
   logic                sel_last;

   // Valid/ready: a beat moves on a port only in a cycle where both tvalid and tready
   // are high; tvalid never waits on tready, and the output holds while tvalid && !tready.
   assign accept = !o_m_axis_tvalid || i_m_axis_tready;
   assign cand   = i_s_axis_tvalid & i_port_enable;

   // Rotating the doubled candidate vector by the pointer turns the wrap-around
   // search into a plain lowest-bit search; MODE 1 simply never rotates.
   always_comb begin
      base      = (MODE == 0) ? r_ptr : '0;
      rot       = N_PORTS'({cand, cand} >> base);
      arb_found = 1'b0;
      arb_idx   = '0;
      sum       = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (!arb_found && rot[i]) begin
            arb_found = 1'b1;
            sum       = CW'(base) + CW'(i);
            if (sum >= CW'(N_PORTS)) sum = sum - CW'(N_PORTS);
            arb_idx   = sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      if (r_state == S_LOCKED) begin
         grant     = r_grant;
         grant_vld = 1'b1;
      end else begin
         grant     = arb_idx;
         grant_vld = arb_found;
      end
   end

   always_comb begin
      o_s_axis_tready = '0;
      sel_data        = '0;
      sel_last        = 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (grant == ID_W'(k)) begin
            o_s_axis_tready[k] = !i_rst && grant_vld && accept;
            sel_data           = i_s_axis_tdata[k*DATA_W +: DATA_W];
            sel_last           = i_s_axis_tlast[k];
         end
      end
   end

   assign hs       = |(o_s_axis_tready & i_s_axis_tvalid);
   assign next_ptr = (grant == ID_W'(N_PORTS - 1)) ? '0 : grant + ID_W'(1);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= S_IDLE;
         r_ptr           <= '0;
         r_grant         <= '0;
         o_m_axis_tdata  <= '0;
         o_m_axis_tvalid <= 1'b0;
         o_m_axis_tlast  <= 1'b0;
         o_m_axis_tid    <= '0;
      end else begin
         if (hs) begin
            o_m_axis_tdata  <= sel_data;
            o_m_axis_tlast  <= sel_last;
            o_m_axis_tid    <= grant;
            o_m_axis_tvalid <= 1'b1;
            unique case (r_state)
               S_IDLE: begin
                  if (!sel_last) begin
                     r_grant <= grant;
                     r_state <= S_LOCKED;
                  end else begin
                     r_ptr   <= next_ptr;
                  end
               end
               S_LOCKED: begin
                  if (sel_last) begin
                     r_state <= S_IDLE;
                     r_ptr   <= next_ptr;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end else if (i_m_axis_tready) begin
            o_m_axis_tvalid <= 1'b0;
         end
      end
   end

   // The FSM has two states, so busy is the state register itself.
   assign o_busy    = (r_state == S_LOCKED);
   assign o_dbg_ptr = r_ptr;

endmodule
